// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: key/exponent widths, multiplier latency, controller states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rsa_pkg;

  localparam int KEY_W  = 16;
  localparam int EXP_W  = 8;
  // start edge, then one edge per multiplier bit
  localparam int MM_LAT = KEY_W + 1;

  // Controller states shared by the public- and private-key exponentiators
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RED  = 3'd2,
    ST_MUL  = 3'd3,
    ST_SQR  = 3'd4,
    ST_FIN  = 3'd5
  } rsa_state_t;

endpackage

// File: rtl/modmul_il.sv
// Interleaved MSB-first shift-add modular multiplier: P = A*B mod n (requires B < n).
// Latency: WIDTH+1 cycles from the edge sampling start to the cycle where done is high.
// Backpressure: none; start is taken on any edge and restarts the unit, dropping a run in flight.
module modmul_il
  import rsa_pkg::*;
#(
  parameter int WIDTH = KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] P
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] p_q;
  logic [CW-1:0]    k_q;
  logic             run_q;

  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] sub1;
  logic [WIDTH-1:0] p_nxt;

  // One iteration: 2P + (A[k] ? B : 0) stays below 3n, so two conditional subtractions bring it back under n
  always_comb begin
    n_ext = {2'b00, n_q};
    acc   = {1'b0, p_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    sub1  = (acc >= n_ext) ? (acc - n_ext) : acc;
    p_nxt = (sub1 >= n_ext) ? WIDTH'(sub1 - n_ext) : sub1[WIDTH-1:0];
  end

  // Operand capture on start, then WIDTH shift/accumulate steps; done pulses after the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      p_q   <= '0;
      k_q   <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_q   <= A;
        b_q   <= B;
        n_q   <= n;
        p_q   <= '0;
        k_q   <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        p_q <= p_nxt;
        a_q <= {a_q[WIDTH-2:0], 1'b0};
        if (k_q == CW'(WIDTH - 1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  assign P = p_q;

endmodule

// File: rtl/rsa_encrypt.sv
// RSA public-key exponentiation C = M^e mod n, constant-time right-to-left square-and-multiply.
// Latency: 1 + (2*EXP_WIDTH+1)*(WIDTH+1) cycles accept-to-done (290 at defaults); 2 cycles when n < 2.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module rsa_encrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH     = KEY_W,
  parameter int EXP_WIDTH = EXP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     n,
  output logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(EXP_WIDTH - 1);

  rsa_state_t           state;
  logic [EXP_WIDTH-1:0] e_q;
  logic [WIDTH-1:0]     n_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     base_q;
  logic [IW-1:0]        idx_q;
  logic                 bad_q;

  logic                 mm_start;
  logic [WIDTH-1:0]     mm_a;
  logic [WIDTH-1:0]     mm_b;
  logic [WIDTH-1:0]     mm_n;
  logic                 mm_done;
  logic [WIDTH-1:0]     mm_p;

  // Multiplier issue: the reduction M*1 is launched on the accept edge straight from the inputs,
  // and every later multiply is launched in the cycle the previous one reports done, using its
  // fresh product as the operand where the next step needs it.
  always_comb begin
    mm_start = 1'b0;
    mm_a     = result_q;
    mm_b     = mm_p;
    mm_n     = n_q;
    unique case (state)
      ST_IDLE: begin
        mm_start = start;
        mm_a     = M;
        mm_b     = WIDTH'(1);
        mm_n     = n;
      end
      ST_RED: begin
        mm_start = mm_done;
        mm_a     = result_q;
        mm_b     = mm_p;
      end
      ST_MUL: begin
        mm_start = mm_done;
        mm_a     = base_q;
        mm_b     = base_q;
      end
      ST_SQR: begin
        mm_start = mm_done && (idx_q != LAST_IDX);
        mm_a     = result_q;
        mm_b     = mm_p;
      end
      default: begin
        mm_start = 1'b0;
      end
    endcase
  end

  modmul_il #(
    .WIDTH(WIDTH)
  ) u_modmul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mm_start),
    .A    (mm_a),
    .B    (mm_b),
    .n    (mm_n),
    .done (mm_done),
    .P    (mm_p)
  );

  // Exponentiation controller: every exponent bit costs one multiply and one square regardless of its value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      e_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      C        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            e_q   <= e;
            n_q   <= n;
            bad_q <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (n_q < WIDTH'(2)) begin
            bad_q <= 1'b1;
            state <= ST_FIN;
          end else begin
            result_q <= WIDTH'(1);
            idx_q    <= '0;
            state    <= ST_RED;
          end
        end
        ST_RED: begin
          if (mm_done) begin
            base_q <= mm_p;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mm_done) begin
            if (e_q[idx_q]) begin
              result_q <= mm_p;
            end
            state <= ST_SQR;
          end
        end
        ST_SQR: begin
          if (mm_done) begin
            base_q <= mm_p;
            if (idx_q == LAST_IDX) begin
              state <= ST_FIN;
            end else begin
              idx_q <= idx_q + 1'b1;
              state <= ST_MUL;
            end
          end
        end
        ST_FIN: begin
          C     <= bad_q ? '0 : result_q;
          err   <= bad_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
